// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port between NUM_REQ requesters.
// Round-robin arbitration, SETUP/ACCESS sequencing, PREADY wait states, and
// a one-cycle response pulse back to the owner of each completed transfer.
// Optional feature macro: APB_TIMEOUT_EN (aborts ACCESS phases that wait
// TIMEOUT_CYCLES cycles for PREADY, answering with rsp_err=1, rsp_rdata=0).
module apb_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic                          PWRITE,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("apb_master_arbiter: parameter out of range");
  end

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic [PTR_W-1:0]        cand;
  logic [PTR_W-1:0]        win_idx;
  logic                    win_found;
  logic                    grant_opp;
  logic                    grant_en;
  logic                    tmo_hit;

  // Unpack per-requester payloads and decode the one-hot accept strobe.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready[gi] = grant_en && (win_idx == PTR_W'(gi));
  end

  // Round-robin search starting just after the last owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A grant may be issued when idle or when the current ACCESS completes.
  assign grant_opp = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && PREADY);
  assign grant_en  = grant_opp && win_found && !PRESET;

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == ST_ACCESS) && !PREADY &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Count stalled ACCESS cycles; any other state restarts from zero.
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == ST_ACCESS) && !PREADY && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and registered-output computation for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          rsp_valid_d[ptr_q] = 1'b1;
          rsp_rdata_d        = PRDATA;
          rsp_err_d          = PSLVERR;
          state_d            = ST_IDLE;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
        end else if (tmo_hit) begin
          rsp_valid_d[ptr_q] = 1'b1;
          rsp_rdata_d        = '0;
          rsp_err_d          = 1'b1;
          state_d            = ST_IDLE;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
    // A grant overrides the idle return, giving back-to-back SETUP phases.
    if (grant_en) begin
      state_d   = ST_SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      ptr_d     = win_idx;
      paddr_d   = addr_arr[win_idx];
      pwrite_d  = req_write[win_idx];
      pwdata_d  = wdata_arr[win_idx];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_W'(NUM_REQ - 1);
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ internal requesters, such as the AHB-to-APB bridge datapath, a DMA engine and a debug port.
- Each requester uses a simple valid/ready command interface and receives a one-cycle response pulse.
- The block runs round-robin arbitration, sequences the APB SETUP/ACCESS phases, honours PREADY wait states and returns PRDATA/PSLVERR to the requester that owns the transfer.

Parameters:
- NUM_REQ, 4, number of requesters (2 to 8).
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only when APB_TIMEOUT_EN is defined.

Ports:
- PCLK  in  1  single clock for the whole block.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_write  in  NUM_REQ  per-requester direction: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data; requester i occupies slice i.
- req_ready  out  NUM_REQ  one-hot command-accept strobe.
- rsp_valid  out  NUM_REQ  one-hot response strobe, one cycle long.
- rsp_rdata  out  DATA_WIDTH  read data, shared; qualified by rsp_valid.
- rsp_err  out  1  error flag, shared; qualified by rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready / wait-state control.
- PSLVERR  in  1  APB slave error.

Behaviour:
- States: ST_IDLE, ST_SETUP, ST_ACCESS.
- Reset (synchronous, PRESET=1 at a PCLK edge):
  - State goes to ST_IDLE.
  - All outputs are 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_err.
  - Round-robin pointer is set to NUM_REQ-1, so requester 0 wins first.
  - Reset asserted mid-transfer abandons the transfer with no response pulse. PSEL drops the following cycle.
- Arbitration:
  - Grant opportunity exists in ST_IDLE, and in ST_ACCESS when PREADY=1.
  - Winner is the first i with req_valid[i]=1, searching from pointer+1 upward and wrapping modulo NUM_REQ.
  - On a grant opportunity with a winner, req_ready[winner]=1 in that cycle (combinational, one-hot).
  - At that edge the block latches req_addr, req_write and req_wdata of the winner into PADDR, PWRITE and PWDATA, sets pointer to the winner, and enters ST_SETUP.
  - No winner: go to, or stay in, ST_IDLE.
  - req_ready is never asserted in ST_SETUP, or in ST_ACCESS while PREADY=0.
- Requester rules:
  - req_valid stays high, with payload stable, until req_ready is seen.
  - A requester may deassert req_valid before it is granted; it is then simply skipped.
- ST_SETUP: PSEL=1, PENABLE=0. Always advances to ST_ACCESS.
- ST_ACCESS:
  - PSEL=1, PENABLE=1.
  - PREADY=0: stay in ST_ACCESS; PADDR, PWRITE and PWDATA are held.
  - PREADY=1: the transfer completes.
    - Next cycle: rsp_valid[owner]=1, rsp_rdata=PRDATA (registered; undefined-by-contract for writes, but still driven with the sampled value), rsp_err=PSLVERR.
    - If another grant occurs in the same cycle, go directly to ST_SETUP (back-to-back: PSEL stays 1, PENABLE drops to 0).
    - Otherwise go to ST_IDLE and drive PSEL=0 and PENABLE=0.
- PADDR, PWRITE and PWDATA keep their last values while idle.
- Latency:
  - Zero-wait read from idle: req_ready at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3.
  - Each PREADY=0 cycle adds 1.
- Throughput: with continuous requests, one transfer every 2 cycles.
- Simultaneous events:
  - A response pulse for the finishing transfer and req_ready for the next grant may occur in the same cycle, to different or the same requester.
  - The owner of the just-completed transfer has the lowest priority in the next arbitration.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A counter runs in ST_ACCESS and clears on entering ST_SETUP.
  - If it reaches TIMEOUT_CYCLES-1 with PREADY still 0, the transfer is aborted.
  - Abort: go to ST_IDLE, PSEL and PENABLE drop next cycle, rsp_valid[owner]=1 with rsp_err=1 and rsp_rdata=0.
  - No grant is issued in the abort cycle.
- Not defined: no counter; the block waits for PREADY indefinitely.

Test Plan:
- Single read: req_valid[0]=1, req_write=0, addr 0x0000_1000; slave returns PRDATA=0xDEAD_BEEF with 0 waits -> req_ready[0] at cycle 0, PSEL cycles 1-2, PENABLE cycle 2, rsp_valid[0] cycle 3, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Write with waits: req 2 writes 0xA5A5_A5A5 to 0x40; PREADY low 3 cycles -> PADDR/PWDATA stable through ACCESS, rsp_valid[2] at cycle 6, rsp_err=0.
- Round-robin: all 4 req_valid high continuously, 0 waits -> grant order 0,1,2,3,0; PSEL never drops; a new SETUP every 2 cycles.
- Slave error: PSLVERR=1 with PREADY on req 1 read -> rsp_valid[1]=1, rsp_err=1.
- Reset mid-ACCESS: PRESET=1 while PREADY=0 -> next cycle all outputs 0, no rsp_valid; after release, requester 0 wins first.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=8: PREADY held 0 -> exactly 8 ACCESS cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0, PSEL low the following cycle.
